// File: rtl/config_bank_loader.sv
// Per-tile config loader: a serial shift register that commits checked, full-length words into one of
// several shadow banks, and drives config_bits from whichever bank is currently active.
module config_bank_loader #(
  parameter int LENGTH      = 8,
  parameter int SHIFT_WIDTH = 1,
  parameter int BANKS       = 2,
  localparam int BSEL_W     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic [SHIFT_WIDTH-1:0] shift_in,
  output logic [SHIFT_WIDTH-1:0] shift_out,
  input  logic                   set,
  input  logic [BSEL_W-1:0]      set_bank,
  input  logic                   ctx_switch,
  input  logic [BSEL_W-1:0]      ctx_sel,
  output logic [LENGTH-1:0]      config_bits,
  output logic [BSEL_W-1:0]      active_bank,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] sr_q, sr_d, sr_shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] bank_q [BANKS];
  logic [BSEL_W-1:0] active_q, active_d;
  logic              done_d, err_d, bank_we;
  logic              bank_ok, sel_ok;
  logic [31:0]       cnt_sum;

  // When one shift fills the whole register there is no older data to keep.
  if (LENGTH > SHIFT_WIDTH) begin : g_shift_keep
    assign sr_shifted = {sr_q[LENGTH-SHIFT_WIDTH-1:0], shift_in};
  end else begin : g_shift_replace
    assign sr_shifted = shift_in;
  end

  assign shift_out   = sr_q[LENGTH-1 -: SHIFT_WIDTH];
  assign config_bits = bank_q[active_q];
  assign active_bank = active_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    bank_we  = 1'b0;
    done_d   = 1'b0;
    err_d    = load_err;
    cnt_sum  = 32'(cnt_q) + 32'(SHIFT_WIDTH);
    bank_ok  = 32'(set_bank) < 32'(BANKS);
    sel_ok   = 32'(ctx_sel) < 32'(BANKS);

    // Every commit attempt, good or bad, restarts the bit count; set also blocks a same-cycle shift.
    if (set) begin
      state_d = EMPTY;
      cnt_d   = '0;
      if (state_q == FULL && bank_ok) begin
        bank_we = 1'b1;
        done_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (shift_en) begin
      sr_d = sr_shifted;
      if (cnt_sum >= 32'(LENGTH)) begin
        cnt_d   = CNT_W'(LENGTH);
        state_d = FULL;
      end else begin
        cnt_d   = CNT_W'(cnt_sum);
        state_d = FILLING;
      end
    end

    if (ctx_switch) begin
      if (sel_ok) begin
        active_d = ctx_sel;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      sr_q      <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      for (int i = 0; i < BANKS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      load_done <= done_d;
      load_err  <= err_d;
      if (bank_we) begin
        bank_q[set_bank] <= sr_q;
      end
    end
  end

endmodule

// File: tb/tb_config_bank_loader.sv
// Scoreboarded bench for config_bank_loader: a bit-level reference model predicts every cycle's
// outputs, and an independent monitor compares them one step after each clock edge.
module tb_config_bank_loader;

  localparam int L  = 8;
  localparam int SW = 1;
  localparam int NB = 3;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          shift_en = 1'b0;
  logic [SW-1:0] shift_in = '0;
  logic [SW-1:0] shift_out;
  logic          set = 1'b0;
  logic [BW-1:0] set_bank = '0;
  logic          ctx_switch = 1'b0;
  logic [BW-1:0] ctx_sel = '0;
  logic [L-1:0]  config_bits;
  logic [BW-1:0] active_bank;
  logic          load_done;
  logic          load_err;

  config_bank_loader #(.LENGTH(L), .SHIFT_WIDTH(SW), .BANKS(NB)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .shift_in(shift_in), .shift_out(shift_out),
    .set(set), .set_bank(set_bank), .ctx_switch(ctx_switch), .ctx_sel(ctx_sel),
    .config_bits(config_bits), .active_bank(active_bank), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0]  cfg;
    logic [BW-1:0] act;
    logic          done;
    logic          err;
    logic [SW-1:0] sout;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: the last L bits seen, how many bits arrived since the last commit attempt, banks.
  logic [L-1:0] m_sr;
  int           m_cnt;
  logic [L-1:0] m_bank [NB];
  int           m_active;
  logic         m_err;

  function automatic void modelStep(input logic r, input logic se, input logic [SW-1:0] si,
                                    input logic st, input int sb, input logic cs, input int csel,
                                    output exp_t e);
    logic done;
    done = 1'b0;
    if (r) begin
      m_sr = '0; m_cnt = 0; m_active = 0; m_err = 1'b0;
      for (int i = 0; i < NB; i++) m_bank[i] = '0;
    end else begin
      if (st) begin
        if (m_cnt >= L && sb < NB) begin
          m_bank[sb] = m_sr;
          done = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_cnt = 0;
      end else if (se) begin
        for (int b = SW - 1; b >= 0; b--) m_sr = {m_sr[L-2:0], si[b]};
        m_cnt = (m_cnt + SW > L) ? L : m_cnt + SW;
      end
      if (cs) begin
        if (csel < NB) m_active = csel;
        else m_err = 1'b1;
      end
    end
    e.cfg  = m_bank[m_active];
    e.act  = BW'(m_active);
    e.done = done;
    e.err  = m_err;
    e.sout = m_sr[L-1 -: SW];
  endfunction

  task automatic applyStimulus(input logic r, input logic se, input logic [SW-1:0] si,
                               input logic st, input int sb, input logic cs, input int csel);
    exp_t e;
    @(negedge clk);
    rst = r; shift_en = se; shift_in = si; set = st;
    set_bank = BW'(sb); ctx_switch = cs; ctx_sel = BW'(csel);
    modelStep(r, se, si, st, sb, cs, csel, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic shiftByte(input logic [L-1:0] v, input int nbits);
    for (int i = L - 1; i >= L - nbits; i--) applyStimulus(1'b0, 1'b1, SW'(v[i]), 1'b0, 0, 1'b0, 0);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("config_bits", 32'(config_bits), 32'(e.cfg));
    checkField("active_bank", 32'(active_bank), 32'(e.act));
    checkField("load_done",   32'(load_done),   32'(e.done));
    checkField("load_err",    32'(load_err),    32'(e.err));
    checkField("shift_out",   32'(shift_out),   32'(e.sout));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    // Reset with junk on every other input.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1);
    idle(1);
    // Full load of 0xA5 into the active bank.
    shiftByte(8'hA5, 8);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 0, 1'b0, 0);
    idle(2);
    // Short load is rejected and the count restarts.
    shiftByte(8'h5F, 5);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 0, 1'b0, 0);
    shiftByte(8'h00, 3);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1, 1'b0, 0);
    // Background load into bank1, then switch to it.
    shiftByte(8'h3C, 8);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1, 1'b0, 0);
    idle(1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0, 1'b1, 1);
    idle(1);
    // set beats a same-cycle shift; same-cycle switch to the written bank shows the new data.
    shiftByte(8'h5A, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
    idle(2);
    // Reset mid-load, then a clean 0xFF load into bank2; out-of-range bank and context indices.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 0, 1'b0, 0);
    shiftByte(8'h0F, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    shiftByte(8'hFF, 8);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 2, 1'b1, 2);
    idle(1);
    shiftByte(8'h81, 8);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 3, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 0, 1'b1, 1);
    // Randomized traffic biased toward complete loads.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 9) < 8),
                    SW'($urandom),
                    ($urandom_range(0, 10) == 0),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
